// File: rtl/mult_wb_buffer_pkg.sv
// -----------------------------------------------------------------------------
// mult_wb_buffer_pkg
//
// Shared types for functional-unit writeback buffers.
//   XLEN / xlen_t  : architectural register width and its data type
//   TRANS_ID_BITS  : width of the scoreboard transaction id
//   wb_entry_t     : one buffered writeback (result + transaction id), sized so
//                    other units' writeback buffers can store the same record
//   ST_RUN/ST_DRAIN: drain state machine encodings of mult_wb_buffer
// -----------------------------------------------------------------------------
package mult_wb_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        xlen_t                    result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } wb_entry_t;

    // Drain state machine encodings (plain constants for legacy tooling).
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/mult_wb_buffer_fifo.sv
// -----------------------------------------------------------------------------
// mult_wb_buffer_fifo
//
// Small circular FIFO holding wb_entry_t records for mult_wb_buffer.
// Push and pop may happen in the same cycle at any occupancy, including full;
// the caller guarantees that a push into a full FIFO always comes with a pop.
// Pointers are log2(DEPTH) bits and wrap naturally; occupancy is kept in a
// separate counter so full and empty are unambiguous.
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (empties the FIFO)
//   flush_i  : synchronous clear of pointers and occupancy
//   push     : write data_in at the tail
//   data_in  : record to write
//   pop      : advance the head
//   data_out : record at the head (only meaningful while count != 0)
//   count    : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mult_wb_buffer_fifo
    import mult_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push,
    input  wb_entry_t        data_in,
    input  logic             pop,
    output wb_entry_t        data_out,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    wb_entry_t        mem [DEPTH];

    // Control state: pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is data only; its contents are never observed while empty, so it
    // carries no reset.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign data_out = mem[rd_ptr];

endmodule

// File: rtl/mult_wb_buffer.sv
// -----------------------------------------------------------------------------
// mult_wb_buffer
//
// Receiver-side companion to the mult functional unit. The unit cannot stall
// its multiplication results, so this block buffers them in a small FIFO when
// writeback is busy, and throttles issue into the unit with a credit counter
// so the FIFO can never overflow. After a pipeline flush it discards results
// of killed multiplications for MUL_LAT cycles.
//
// Parameters
//   DEPTH   : FIFO entries; power of two and at least MUL_LAT+1
//   MUL_LAT : longest time a multiplication is in flight (>= 1); also the
//             length of the post-flush drain window
//
// Ports
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   flush_i        : pipeline flush
//   issue_valid_i  : issue stage presents a mul/div op
//   issue_ready_o  : gated ready back to issue (accept = valid && ready)
//   unit_ready_i   : mult unit ready (divider idle)
//   res_valid_i    : result valid from the mult unit
//   res_i          : result data
//   res_trans_id_i : result transaction id
//   wb_valid_o     : head entry valid toward writeback
//   wb_result_o    : head result (zero while empty)
//   wb_trans_id_o  : head transaction id (zero while empty)
//   wb_ready_i     : writeback accepts the head entry
//   credits_o      : free credits, DEPTH - reserved
// -----------------------------------------------------------------------------
module mult_wb_buffer
    import mult_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic                     unit_ready_i,
    input  logic                     res_valid_i,
    input  logic [XLEN-1:0]          res_i,
    input  logic [TRANS_ID_BITS-1:0] res_trans_id_i,
    output logic                     wb_valid_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    input  logic                     wb_ready_i,
    output logic [$clog2(DEPTH):0]   credits_o
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned DRAIN_W = $clog2(MUL_LAT + 1);

    logic [CNT_W-1:0]   reserved;
    logic [CNT_W-1:0]   fifo_count;
    logic [DRAIN_W-1:0] drain;
    logic [0:0]         state;
    logic [0:0]         state_next;
    logic               draining;
    logic               issue_acc;
    logic               wb_acc;
    logic               push;
    logic               pop;
    wb_entry_t          push_entry;
    wb_entry_t          head_entry;

    assign draining = (drain != '0);

    // A credit is taken at issue, not at result, so results already in flight
    // always have a FIFO slot waiting for them.
    assign issue_ready_o = unit_ready_i && !flush_i && !draining
                           && (reserved < CNT_W'(DEPTH));
    assign issue_acc     = issue_valid_i && issue_ready_o;

    assign wb_valid_o = (fifo_count != '0);
    assign wb_acc     = wb_valid_o && wb_ready_i;

    // Flush dominates both a same-cycle push and a same-cycle pop.
    assign push = res_valid_i && !draining && !flush_i;
    assign pop  = wb_acc && !flush_i;

    assign push_entry.result   = res_i;
    assign push_entry.trans_id = res_trans_id_i;

    mult_wb_buffer_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .push     (push),
        .data_in  (push_entry),
        .pop      (pop),
        .data_out (head_entry),
        .count    (fifo_count)
    );

    // Head is held by the FIFO until popped, so the outputs are stable under
    // backpressure; they read as zero while nothing is buffered.
    assign wb_result_o   = wb_valid_o ? head_entry.result   : '0;
    assign wb_trans_id_o = wb_valid_o ? head_entry.trans_id : '0;

    // Reserved = in flight + buffered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved <= '0;
        end else if (flush_i) begin
            reserved <= '0;
        end else if (issue_acc && !wb_acc) begin
            reserved <= reserved + CNT_W'(1);
        end else if (!issue_acc && wb_acc) begin
            reserved <= reserved - CNT_W'(1);
        end
    end

    assign credits_o = CNT_W'(DEPTH) - reserved;

    // Drain window: results arriving within MUL_LAT cycles of a flush belong
    // to killed multiplications. A flush during the window restarts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain <= '0;
        end else if (flush_i) begin
            drain <= DRAIN_W'(MUL_LAT);
        end else if (draining) begin
            drain <= drain - DRAIN_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = ST_DRAIN;
        end else if ((state == ST_DRAIN) && (drain == DRAIN_W'(1))) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_mult_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_mult_wb_buffer
//
// Directed bench for mult_wb_buffer. The bench plays both the issue stage and
// the mult unit; inputs change 1 time unit after the rising edge and outputs
// are sampled 1 unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_mult_wb_buffer;
    import mult_wb_buffer_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 2;

    logic                     clk_i          = 1'b0;
    logic                     rst_ni         = 1'b0;
    logic                     flush_i        = 1'b0;
    logic                     issue_valid_i  = 1'b0;
    logic                     unit_ready_i   = 1'b1;
    logic                     res_valid_i    = 1'b0;
    logic [XLEN-1:0]          res_i          = '0;
    logic [TRANS_ID_BITS-1:0] res_trans_id_i = '0;
    logic                     wb_ready_i     = 1'b1;
    logic                     issue_ready_o;
    logic                     wb_valid_o;
    logic [XLEN-1:0]          wb_result_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [2:0]               credits_o;

    int total = 0;
    int bad   = 0;

    mult_wb_buffer #(
        .DEPTH   (DEPTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .unit_ready_i   (unit_ready_i),
        .res_valid_i    (res_valid_i),
        .res_i          (res_i),
        .res_trans_id_i (res_trans_id_i),
        .wb_valid_o     (wb_valid_o),
        .wb_result_o    (wb_result_o),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_ready_i     (wb_ready_i),
        .credits_o      (credits_o)
    );

    always #5 clk_i = ~clk_i;

    // A push into a full FIFO without a same-cycle pop must never happen.
    always @(posedge clk_i) begin
        if (rst_ni && dut.push && !dut.pop && (dut.u_fifo.count == 3'(DEPTH))) begin
            bad++;
            $display("FAIL fifo_overflow: push at count=%0d without pop, required no push", dut.u_fifo.count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task step();
        @(posedge clk_i);
        #1;
    endtask

    task test_reset();
        rst_ni = 1'b0;
        unit_ready_i = 1'b1;
        step();
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b0, 64'h0, 3'd0}) begin
            bad++;
            $display("FAIL reset_wb: got v=%0b r=%h id=%0d required v=0 r=0 id=0", wb_valid_o, wb_result_o, wb_trans_id_o);
        end
        total++;
        if (credits_o !== 3'd4) begin
            bad++;
            $display("FAIL reset_credits: got %0d required 4", credits_o);
        end
        total++;
        if (issue_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_issue_ready_hi: got %0b required 1", issue_ready_o);
        end
        unit_ready_i = 1'b0;
        #1;
        total++;
        if (issue_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_issue_ready_lo: got %0b required 0", issue_ready_o);
        end
        unit_ready_i = 1'b1;
        step();
        rst_ni = 1'b1;
        step();
        total++;
        if ({wb_valid_o, credits_o, issue_ready_o} !== {1'b0, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL reset_release: got v=%0b cr=%0d rdy=%0b required v=0 cr=4 rdy=1", wb_valid_o, credits_o, issue_ready_o);
        end
    endtask

    task test_back_to_back();
        wb_ready_i    = 1'b1;
        issue_valid_i = 1'b1;
        step();
        res_valid_i = 1'b1; res_i = 64'h11; res_trans_id_i = 3'd1;
        #1;
        total++;
        if (wb_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_bypass: got v=%0b required 0", wb_valid_o);
        end
        step();
        res_i = 64'h22; res_trans_id_i = 3'd2;
        #1;
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, 64'h11, 3'd1}) begin
            bad++;
            $display("FAIL b2b_first: got v=%0b r=%h id=%0d required v=1 r=11 id=1", wb_valid_o, wb_result_o, wb_trans_id_o);
        end
        total++;
        if (credits_o !== 3'd2) begin
            bad++;
            $display("FAIL b2b_credits_mid: got %0d required 2", credits_o);
        end
        step();
        issue_valid_i = 1'b0;
        res_i = 64'h33; res_trans_id_i = 3'd3;
        #1;
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, 64'h22, 3'd2}) begin
            bad++;
            $display("FAIL b2b_second: got v=%0b r=%h id=%0d required v=1 r=22 id=2", wb_valid_o, wb_result_o, wb_trans_id_o);
        end
        step();
        res_valid_i = 1'b0;
        #1;
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, 64'h33, 3'd3}) begin
            bad++;
            $display("FAIL b2b_third: got v=%0b r=%h id=%0d required v=1 r=33 id=3", wb_valid_o, wb_result_o, wb_trans_id_o);
        end
        step();
        #1;
        total++;
        if ({wb_valid_o, credits_o} !== {1'b0, 3'd4}) begin
            bad++;
            $display("FAIL b2b_end: got v=%0b cr=%0d required v=0 cr=4", wb_valid_o, credits_o);
        end
    endtask

    task test_backpressure();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue_valid_i  = (i < 4);
            res_valid_i    = (i > 0);
            res_i          = XLEN'(17 * i);
            res_trans_id_i = TRANS_ID_BITS'(i);
            #1;
            if (i >= 3) begin
                total++;
                if (issue_ready_o !== (i == 3)) begin
                    bad++;
                    $display("FAIL bp_issue_ready_%0d: got %0b required %0b", i, issue_ready_o, (i == 3));
                end
            end
            if (i >= 2) begin
                total++;
                if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, 64'h11, 3'd1}) begin
                    bad++;
                    $display("FAIL bp_head_stable_%0d: got v=%0b r=%h id=%0d required v=1 r=11 id=1", i, wb_valid_o, wb_result_o, wb_trans_id_o);
                end
            end
            step();
        end
        res_valid_i   = 1'b0;
        issue_valid_i = 1'b1;
        #1;
        total++;
        if ({dut.u_fifo.count, credits_o, issue_ready_o} !== {3'd4, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL bp_full: got cnt=%0d cr=%0d rdy=%0b required cnt=4 cr=0 rdy=0", dut.u_fifo.count, credits_o, issue_ready_o);
        end
        step();
        issue_valid_i = 1'b0;
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o, credits_o} !== {1'b1, 64'h11, 3'd1, 3'd0}) begin
            bad++;
            $display("FAIL bp_hold: got v=%0b r=%h id=%0d cr=%0d required v=1 r=11 id=1 cr=0", wb_valid_o, wb_result_o, wb_trans_id_o, credits_o);
        end
        wb_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++;
            if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, XLEN'(17 * i), TRANS_ID_BITS'(i)}) begin
                bad++;
                $display("FAIL bp_drain_%0d: got v=%0b r=%h id=%0d required v=1 r=%h id=%0d", i, wb_valid_o, wb_result_o, wb_trans_id_o, 17 * i, i);
            end
            total++;
            if (issue_ready_o !== (i > 1)) begin
                bad++;
                $display("FAIL bp_ready_after_pop_%0d: got %0b required %0b", i, issue_ready_o, (i > 1));
            end
            step();
        end
        #1;
        total++;
        if ({wb_valid_o, credits_o} !== {1'b0, 3'd4}) begin
            bad++;
            $display("FAIL bp_end: got v=%0b cr=%0d required v=0 cr=4", wb_valid_o, credits_o);
        end
    endtask

    task test_full_push_pop();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue_valid_i  = (i < 4);
            res_valid_i    = (i > 0);
            res_i          = XLEN'(17 * i);
            res_trans_id_i = TRANS_ID_BITS'(i);
            step();
        end
        issue_valid_i  = 1'b0;
        wb_ready_i     = 1'b1;
        res_valid_i    = 1'b1;
        res_i          = 64'h55;
        res_trans_id_i = 3'd5;
        #1;
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, 64'h11, 3'd1}) begin
            bad++;
            $display("FAIL full_pp_head: got v=%0b r=%h id=%0d required v=1 r=11 id=1", wb_valid_o, wb_result_o, wb_trans_id_o);
        end
        step();
        wb_ready_i  = 1'b0;
        res_valid_i = 1'b0;
        #1;
        total++;
        if ({dut.u_fifo.count, wb_result_o, wb_trans_id_o} !== {3'd4, 64'h22, 3'd2}) begin
            bad++;
            $display("FAIL full_pp_count: got cnt=%0d r=%h id=%0d required cnt=4 r=22 id=2", dut.u_fifo.count, wb_result_o, wb_trans_id_o);
        end
        wb_ready_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            #1;
            total++;
            if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, XLEN'(17 * i), TRANS_ID_BITS'(i)}) begin
                bad++;
                $display("FAIL full_pp_order_%0d: got v=%0b r=%h id=%0d required v=1 r=%h id=%0d", i, wb_valid_o, wb_result_o, wb_trans_id_o, 17 * i, i);
            end
            step();
        end
        #1;
        total++;
        if (wb_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL full_pp_empty: got v=%0b required 0", wb_valid_o);
        end
        // Clear the credit imbalance created by the unreserved 0x55 result.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        step();
        #1;
        total++;
        if ({credits_o, issue_ready_o} !== {3'd4, 1'b1}) begin
            bad++;
            $display("FAIL full_pp_recover: got cr=%0d rdy=%0b required cr=4 rdy=1", credits_o, issue_ready_o);
        end
    endtask

    task test_flush_drain();
        wb_ready_i    = 1'b0;
        issue_valid_i = 1'b1;
        step();
        res_valid_i = 1'b1; res_i = 64'h11; res_trans_id_i = 3'd1;
        step();
        res_i = 64'h22; res_trans_id_i = 3'd2;
        step();
        issue_valid_i = 1'b0;
        res_valid_i   = 1'b0;
        flush_i       = 1'b1;
        wb_ready_i    = 1'b1;
        #1;
        total++;
        if ({dut.u_fifo.count, credits_o, issue_ready_o} !== {3'd2, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL flush_pre: got cnt=%0d cr=%0d rdy=%0b required cnt=2 cr=1 rdy=0", dut.u_fifo.count, credits_o, issue_ready_o);
        end
        step();
        flush_i       = 1'b0;
        res_valid_i   = 1'b1;
        res_i         = 64'h99;
        res_trans_id_i = 3'd7;
        issue_valid_i = 1'b1;
        #1;
        total++;
        if ({wb_valid_o, issue_ready_o, credits_o} !== {1'b0, 1'b0, 3'd4}) begin
            bad++;
            $display("FAIL flush_after1: got v=%0b rdy=%0b cr=%0d required v=0 rdy=0 cr=4", wb_valid_o, issue_ready_o, credits_o);
        end
        step();
        res_valid_i = 1'b0;
        #1;
        total++;
        if ({wb_valid_o, issue_ready_o} !== {1'b0, 1'b0}) begin
            bad++;
            $display("FAIL flush_after2_discard: got v=%0b rdy=%0b required v=0 rdy=0", wb_valid_o, issue_ready_o);
        end
        step();
        issue_valid_i = 1'b0;
        #1;
        total++;
        if ({wb_valid_o, issue_ready_o, credits_o} !== {1'b0, 1'b1, 3'd4}) begin
            bad++;
            $display("FAIL flush_done: got v=%0b rdy=%0b cr=%0d required v=0 rdy=1 cr=4", wb_valid_o, issue_ready_o, credits_o);
        end
    endtask

    task test_flush_during_drain();
        flush_i = 1'b1;
        step();
        #1;
        total++;
        if (issue_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL refl_first: got rdy=%0b required 0", issue_ready_o);
        end
        step();
        flush_i = 1'b0;
        res_valid_i = 1'b1; res_i = 64'h77; res_trans_id_i = 3'd6;
        #1;
        total++;
        if (issue_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL refl_hold1: got rdy=%0b required 0", issue_ready_o);
        end
        step();
        res_valid_i = 1'b0;
        #1;
        total++;
        if ({issue_ready_o, wb_valid_o} !== {1'b0, 1'b0}) begin
            bad++;
            $display("FAIL refl_hold2: got rdy=%0b v=%0b required rdy=0 v=0", issue_ready_o, wb_valid_o);
        end
        step();
        #1;
        total++;
        if ({issue_ready_o, wb_valid_o} !== {1'b1, 1'b0}) begin
            bad++;
            $display("FAIL refl_done: got rdy=%0b v=%0b required rdy=1 v=0", issue_ready_o, wb_valid_o);
        end
    endtask

    task test_reset_mid();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_valid_i  = (i < 3);
            res_valid_i    = (i > 0);
            res_i          = XLEN'(17 * i);
            res_trans_id_i = TRANS_ID_BITS'(i);
            step();
        end
        res_valid_i = 1'b0;
        #1;
        total++;
        if ({dut.u_fifo.count, wb_valid_o, credits_o} !== {3'd3, 1'b1, 3'd1}) begin
            bad++;
            $display("FAIL rst_mid_pre: got cnt=%0d v=%0b cr=%0d required cnt=3 v=1 cr=1", dut.u_fifo.count, wb_valid_o, credits_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o, credits_o} !== {1'b0, 64'h0, 3'd0, 3'd4}) begin
            bad++;
            $display("FAIL rst_mid_async: got v=%0b r=%h id=%0d cr=%0d required v=0 r=0 id=0 cr=4", wb_valid_o, wb_result_o, wb_trans_id_o, credits_o);
        end
        step();
        step();
        rst_ni     = 1'b1;
        wb_ready_i = 1'b1;
        step();
        total++;
        if ({wb_valid_o, dut.u_fifo.count, credits_o, issue_ready_o} !== {1'b0, 3'd0, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL rst_mid_release: got v=%0b cnt=%0d cr=%0d rdy=%0b required v=0 cnt=0 cr=4 rdy=1", wb_valid_o, dut.u_fifo.count, credits_o, issue_ready_o);
        end
        issue_valid_i = 1'b1;
        step();
        issue_valid_i = 1'b0;
        res_valid_i = 1'b1; res_i = 64'hAB; res_trans_id_i = 3'd3;
        step();
        res_valid_i = 1'b0;
        #1;
        total++;
        if ({wb_valid_o, wb_result_o, wb_trans_id_o} !== {1'b1, 64'hAB, 3'd3}) begin
            bad++;
            $display("FAIL rst_mid_resume: got v=%0b r=%h id=%0d required v=1 r=ab id=3", wb_valid_o, wb_result_o, wb_trans_id_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_full_push_pop();
        test_flush_drain();
        test_flush_during_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
